// File: rtl/axonerve_wordcount_burst_scheduler.sv
// Read-burst scheduler for the wordcount AXI4 read master.
// Splits a beat-count transfer into fixed-size AR bursts, throttles on an
// outstanding-burst limit, and pulses done once every burst has returned rlast.
module axonerve_wordcount_burst_scheduler #(
    parameter int unsigned C_ADDR_WIDTH      = 64,
    parameter int unsigned C_DATA_WIDTH      = 512,
    parameter int unsigned C_LENGTH_WIDTH    = 32,
    parameter int unsigned C_BURST_LEN       = 64,
    parameter int unsigned C_MAX_OUTSTANDING = 16
) (
    input  logic                                 ap_clk,
    input  logic                                 ap_rst_n,
    input  logic                                 ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]              ctrl_addr_offset,
    input  logic [C_LENGTH_WIDTH-1:0]            ctrl_xfer_beats,
    output logic                                 ctrl_busy,
    output logic                                 ctrl_done,
    output logic                                 m_axi_arvalid,
    input  logic                                 m_axi_arready,
    output logic [C_ADDR_WIDTH-1:0]              m_axi_araddr,
    output logic [7:0]                           m_axi_arlen,
    input  logic                                 m_axi_rvalid,
    input  logic                                 m_axi_rready,
    input  logic                                 m_axi_rlast,
    output logic [$clog2(C_MAX_OUTSTANDING):0]   outstanding
);

    localparam int unsigned OUT_W       = $clog2(C_MAX_OUTSTANDING) + 1;
    localparam int unsigned LOG2_BL     = $clog2(C_BURST_LEN);
    localparam int unsigned BURST_BYTES = C_BURST_LEN * C_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [C_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_LENGTH_WIDTH-1:0] rem_q, rem_d;
    logic [7:0]                last_len_q, last_len_d;
    logic [7:0]                arlen_q, arlen_d;
    logic                      arvalid_q, arvalid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [OUT_W-1:0]          out_q, out_d;
    logic                      zero_q, zero_d;

    logic                      ar_hs_c;
    logic                      r_dec_c;
    logic [LOG2_BL-1:0]        beat_rem_c;

    // Handshake qualifiers; an rlast at count zero is a stray beat and is dropped.
    assign ar_hs_c    = arvalid_q & m_axi_arready;
    assign r_dec_c    = m_axi_rvalid & m_axi_rready & m_axi_rlast & ~zero_q;
    assign beat_rem_c = ctrl_xfer_beats[LOG2_BL-1:0];

    // Outstanding-burst up/down counter next state with registered zero flag.
    always_comb begin
        out_d = out_q;
        if (ar_hs_c && !r_dec_c) begin
            out_d = out_q + OUT_W'(1);
        end else if (!ar_hs_c && r_dec_c) begin
            out_d = out_q - OUT_W'(1);
        end
        zero_d = (out_d == '0);
    end

    // Next-state and registered-output logic for the issue FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        last_len_d = last_len_q;
        case (state_q)
            S_IDLE: begin
                if (ctrl_start) begin
                    addr_d     = ctrl_addr_offset;
                    rem_d      = (ctrl_xfer_beats >> LOG2_BL)
                               + C_LENGTH_WIDTH'(beat_rem_c != '0);
                    last_len_d = (beat_rem_c == '0) ? 8'(C_BURST_LEN - 1)
                                                    : 8'(beat_rem_c) - 8'd1;
                    state_d    = (ctrl_xfer_beats == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ar_hs_c) begin
                    addr_d = addr_q + C_ADDR_WIDTH'(BURST_BYTES);
                    rem_d  = rem_q - C_LENGTH_WIDTH'(1);
                    if (rem_q == C_LENGTH_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (zero_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        arvalid_d = (state_d == S_ISSUE) && (out_d < OUT_W'(C_MAX_OUTSTANDING));
        arlen_d   = (rem_d == C_LENGTH_WIDTH'(1)) ? last_len_d : 8'(C_BURST_LEN - 1);
        busy_d    = (state_d == S_ISSUE) || (state_d == S_DRAIN);
        done_d    = (state_d == S_DONE);
    end

    // State and output registers; reset abandons any in-flight transfer.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            last_len_q <= '0;
            arlen_q    <= '0;
            arvalid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            out_q      <= '0;
            zero_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            last_len_q <= last_len_d;
            arlen_q    <= arlen_d;
            arvalid_q  <= arvalid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            out_q      <= out_d;
            zero_q     <= zero_d;
        end
    end

    assign ctrl_busy     = busy_q;
    assign ctrl_done     = done_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = arlen_q;
    assign outstanding   = out_q;

endmodule

// File: tb/tb_axonerve_wordcount_burst_scheduler.sv
// Scoreboard bench for the wordcount burst scheduler: expected AR bursts are
// queued by the stimulus and checked by an independent AR monitor.
module tb_axonerve_wordcount_burst_scheduler;

    localparam int unsigned AW   = 64;
    localparam int unsigned LW   = 32;
    localparam int unsigned MAXO = 4;
    localparam int unsigned OW   = $clog2(MAXO) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ctrl_start;
    logic [AW-1:0] ctrl_addr_offset;
    logic [LW-1:0] ctrl_xfer_beats;
    logic          ctrl_busy;
    logic          ctrl_done;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic          m_axi_rlast;
    logic [OW-1:0] outstanding;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } ar_t;

    ar_t ar_q[$];
    int  checks   = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    axonerve_wordcount_burst_scheduler #(
        .C_ADDR_WIDTH      (AW),
        .C_DATA_WIDTH      (512),
        .C_LENGTH_WIDTH    (LW),
        .C_BURST_LEN       (64),
        .C_MAX_OUTSTANDING (MAXO)
    ) dut (
        .ap_clk           (clk),
        .ap_rst_n         (rst_n),
        .ctrl_start       (ctrl_start),
        .ctrl_addr_offset (ctrl_addr_offset),
        .ctrl_xfer_beats  (ctrl_xfer_beats),
        .ctrl_busy        (ctrl_busy),
        .ctrl_done        (ctrl_done),
        .m_axi_arvalid    (m_axi_arvalid),
        .m_axi_arready    (m_axi_arready),
        .m_axi_araddr     (m_axi_araddr),
        .m_axi_arlen      (m_axi_arlen),
        .m_axi_rvalid     (m_axi_rvalid),
        .m_axi_rready     (m_axi_rready),
        .m_axi_rlast      (m_axi_rlast),
        .outstanding      (outstanding)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ar(input logic [AW-1:0] addr, input logic [7:0] len);
        ar_t e;
        e.addr = addr;
        e.len  = len;
        ar_q.push_back(e);
    endtask

    task automatic start_xfer(input logic [AW-1:0] addr, input logic [LW-1:0] beats);
        ctrl_start       = 1'b1;
        ctrl_addr_offset = addr;
        ctrl_xfer_beats  = beats;
        tick();
        ctrl_start = 1'b0;
    endtask

    task automatic rlast_pulse();
        m_axi_rvalid = 1'b1;
        m_axi_rready = 1'b1;
        m_axi_rlast  = 1'b1;
        tick();
        m_axi_rvalid = 1'b0;
        m_axi_rready = 1'b0;
        m_axi_rlast  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i = 0;
        while (!ctrl_done && i < budget) begin
            tick();
            i++;
        end
        check({name, "_done"}, 64'(ctrl_done), 64'd1);
        check({name, "_busy_at_done"}, 64'(ctrl_busy), 64'd0);
        tick();
        check({name, "_done_pulse"}, 64'(ctrl_done), 64'd0);
        check({name, "_ar_left"}, 64'(ar_q.size()), 64'd0);
    endtask

    // AR monitor: pops the scoreboard on every handshake and checks stall stability.
    initial begin
        logic          stall_prev = 1'b0;
        logic [AW-1:0] addr_prev  = '0;
        logic [7:0]    len_prev   = '0;
        ar_t           e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && m_axi_arvalid) begin
                    check("ar_stall_addr", m_axi_araddr, addr_prev);
                    check("ar_stall_len", 64'(m_axi_arlen), 64'(len_prev));
                end
                if (m_axi_arvalid && m_axi_arready) begin
                    if (ar_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL ar_unexpected: got addr 0x%0h len %0d expected no AR (t=%0t)",
                                 m_axi_araddr, m_axi_arlen, $time);
                    end else begin
                        e = ar_q.pop_front();
                        check("ar_addr", m_axi_araddr, e.addr);
                        check("ar_len", 64'(m_axi_arlen), 64'(e.len));
                    end
                end
                stall_prev = m_axi_arvalid && !m_axi_arready;
                addr_prev  = m_axi_araddr;
                len_prev   = m_axi_arlen;
            end
        end
    end

    // Watchdog so the bench always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        rst_n            = 1'b0;
        ctrl_start       = 1'b0;
        ctrl_addr_offset = '0;
        ctrl_xfer_beats  = '0;
        m_axi_arready    = 1'b0;
        m_axi_rvalid     = 1'b0;
        m_axi_rready     = 1'b0;
        m_axi_rlast      = 1'b0;
        #12;
        check("rst_busy", 64'(ctrl_busy), 64'd0);
        check("rst_done", 64'(ctrl_done), 64'd0);
        check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("rst_araddr", m_axi_araddr, 64'd0);
        check("rst_arlen", 64'(m_axi_arlen), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 256 beats: four full bursts back to back, done one cycle after last rlast.
        push_ar(64'h1000, 8'd63);
        push_ar(64'h2000, 8'd63);
        push_ar(64'h3000, 8'd63);
        push_ar(64'h4000, 8'd63);
        m_axi_arready = 1'b1;
        start_xfer(64'h1000, 32'd256);
        check("t1_busy", 64'(ctrl_busy), 64'd1);
        check("t1_arvalid", 64'(m_axi_arvalid), 64'd1);
        check("t1_araddr0", m_axi_araddr, 64'h1000);
        check("t1_arlen0", 64'(m_axi_arlen), 64'd63);
        repeat (4) tick();
        check("t1_arvalid_off", 64'(m_axi_arvalid), 64'd0);
        check("t1_outstanding", 64'(outstanding), 64'd4);
        repeat (4) rlast_pulse();
        check("t1_out_zero", 64'(outstanding), 64'd0);
        check("t1_no_early_done", 64'(ctrl_done), 64'd0);
        check("t1_busy_drain", 64'(ctrl_busy), 64'd1);
        wait_done("t1", 1);

        // 130 beats: 63, 63, 1; done only after all three rlasts.
        push_ar(64'h10000, 8'd63);
        push_ar(64'h11000, 8'd63);
        push_ar(64'h12000, 8'd1);
        start_xfer(64'h10000, 32'd130);
        repeat (3) tick();
        check("t2_outstanding", 64'(outstanding), 64'd3);
        repeat (2) rlast_pulse();
        tick();
        check("t2_not_done", 64'(ctrl_done), 64'd0);
        check("t2_busy", 64'(ctrl_busy), 64'd1);
        rlast_pulse();
        wait_done("t2", 4);

        // Throttle: six bursts, limit four; each rlast releases exactly one AR.
        for (int i = 0; i < 6; i++) push_ar(64'h100000 + 64'(i) * 64'h1000, 8'd63);
        start_xfer(64'h100000, 32'd384);
        repeat (6) tick();
        check("t3_throttled", 64'(m_axi_arvalid), 64'd0);
        check("t3_out_max", 64'(outstanding), 64'd4);
        for (int i = 0; i < 2; i++) begin
            rlast_pulse();
            check("t3_release_valid", 64'(m_axi_arvalid), 64'd1);
            check("t3_release_out", 64'(outstanding), 64'd3);
            tick();
            check("t3_reissue_out", 64'(outstanding), 64'd4);
            check("t3_rethrottle", 64'(m_axi_arvalid), 64'd0);
        end
        repeat (4) rlast_pulse();
        wait_done("t3", 4);

        // AR handshake and rlast in the same cycle leave the count unchanged.
        push_ar(64'h50000, 8'd63);
        push_ar(64'h51000, 8'd63);
        m_axi_arready = 1'b0;
        start_xfer(64'h50000, 32'd128);
        check("t4_arvalid", 64'(m_axi_arvalid), 64'd1);
        m_axi_arready = 1'b1;
        tick();
        check("t4_out_one", 64'(outstanding), 64'd1);
        m_axi_rvalid = 1'b1;
        m_axi_rready = 1'b1;
        m_axi_rlast  = 1'b1;
        tick();
        m_axi_rvalid  = 1'b0;
        m_axi_rready  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_arready = 1'b0;
        check("t4_same_cycle", 64'(outstanding), 64'd1);
        check("t4_drain_valid", 64'(m_axi_arvalid), 64'd0);
        rlast_pulse();
        wait_done("t4", 4);

        // Random arready stalls with address wrap across 2^64.
        push_ar(64'hFFFF_FFFF_FFFF_E000, 8'd63);
        push_ar(64'hFFFF_FFFF_FFFF_F000, 8'd63);
        push_ar(64'h0, 8'd63);
        push_ar(64'h1000, 8'd63);
        push_ar(64'h2000, 8'd63);
        start_xfer(64'hFFFF_FFFF_FFFF_E000, 32'd320);
        for (int i = 0; i < 400 && !ctrl_done; i++) begin
            logic r;
            m_axi_arready = 1'($urandom_range(0, 1));
            r = (outstanding != '0) && ($urandom_range(0, 2) == 0);
            m_axi_rvalid = r;
            m_axi_rready = r;
            m_axi_rlast  = r;
            tick();
        end
        m_axi_rvalid  = 1'b0;
        m_axi_rready  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_arready = 1'b1;
        wait_done("t5", 0);

        // Zero-length transfer: immediate done, no AR, never busy.
        start_xfer(64'h5000, 32'd0);
        check("t6_done", 64'(ctrl_done), 64'd1);
        check("t6_busy", 64'(ctrl_busy), 64'd0);
        check("t6_arvalid", 64'(m_axi_arvalid), 64'd0);
        tick();
        check("t6_done_pulse", 64'(ctrl_done), 64'd0);
        check("t6_arvalid_after", 64'(m_axi_arvalid), 64'd0);

        // Start while busy is ignored.
        push_ar(64'h20000, 8'd63);
        push_ar(64'h21000, 8'd63);
        m_axi_arready = 1'b0;
        start_xfer(64'h20000, 32'd128);
        start_xfer(64'h90000, 32'd640);
        m_axi_arready = 1'b1;
        repeat (3) tick();
        check("t7_out", 64'(outstanding), 64'd2);
        check("t7_arvalid", 64'(m_axi_arvalid), 64'd0);
        repeat (2) rlast_pulse();
        wait_done("t7", 4);

        // Reset with two bursts outstanding, then a stray rlast and a fresh run.
        push_ar(64'h30000, 8'd63);
        push_ar(64'h31000, 8'd63);
        start_xfer(64'h30000, 32'd256);
        repeat (2) tick();
        check("t8_out_pre", 64'(outstanding), 64'd2);
        rst_n = 1'b0;
        #1;
        check("t8_rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("t8_rst_out", 64'(outstanding), 64'd0);
        check("t8_rst_busy", 64'(ctrl_busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rlast_pulse();
        check("t8_stray_rlast", 64'(outstanding), 64'd0);
        push_ar(64'h40000, 8'd63);
        start_xfer(64'h40000, 32'd64);
        check("t8_restart_valid", 64'(m_axi_arvalid), 64'd1);
        tick();
        check("t8_restart_out", 64'(outstanding), 64'd1);
        rlast_pulse();
        wait_done("t8", 4);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
